// File: rtl/uart_link_core.sv
// UART link: buffered transmitter and 2-flop-synchronised oversampling receiver sharing one tick.
// Even parity is added to both directions when UART_LINK_PARITY_EN is defined.
module uart_link_core #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic [$clog2(TX_FIFO_DEPTH):0]   tx_fifo_count,
    output logic                             txd,
    output logic                             tx_busy,
    input  logic                             rxd,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    output logic                             rx_frame_err,
    output logic                             rx_parity_err
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = $clog2(DIV + 1);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(TX_FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  DEPTH    = CW'(TX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_LINK_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // TX buffer: tx_ready is registered from the next count, so a full FIFO never takes a word
    logic [DATA_BITS-1:0] mem [TX_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count_d;
    logic                 push, pop;

    assign push = tx_valid && tx_ready;

    always_comb begin
        count_d = tx_fifo_count;
        if (push && !pop)      count_d = tx_fifo_count + 1'b1;
        else if (pop && !push) count_d = tx_fifo_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx_fifo_count <= '0;
            tx_ready      <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            tx_fifo_count <= count_d;
            tx_ready      <= (count_d < DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    state_t               tx_state, tx_state_d;
    logic [OSW-1:0]       tx_cnt, tx_cnt_d;
    logic [BW-1:0]        tx_bit, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
    logic                 txd_d, load, tx_end;
`ifdef UART_LINK_PARITY_EN
    logic                 tx_par, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_sh_d    = tx_sh;
`ifdef UART_LINK_PARITY_EN
        tx_par_d   = tx_par;
`endif
        pop        = 1'b0;
        load       = 1'b0;
        tx_end     = tick && (tx_cnt == OS_LAST);
        if (tx_state != IDLE && tick) tx_cnt_d = tx_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            IDLE:  load = tick && (tx_fifo_count != '0);
            START: if (tx_end) tx_state_d = DATA;
            DATA: begin
                if (tx_end) begin
                    tx_sh_d  = tx_sh >> 1;
                    tx_bit_d = tx_bit + 1'b1;
                    if (tx_bit == BIT_LAST) begin
                        tx_bit_d = '0;
`ifdef UART_LINK_PARITY_EN
                        tx_state_d = PARITY;
`else
                        tx_state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_LINK_PARITY_EN
            PARITY: if (tx_end) tx_state_d = STOP;
`endif
            STOP: begin
                // a waiting word starts straight out of the stop bit, no idle tick in between
                if (tx_end) begin
                    if (tx_fifo_count != '0) load = 1'b1;
                    else                     tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        if (load) begin
            pop        = 1'b1;
            tx_state_d = START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_sh_d    = mem[rd_ptr];
`ifdef UART_LINK_PARITY_EN
            tx_par_d   = ^mem[rd_ptr];
`endif
        end
        case (tx_state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = tx_sh_d[0];
`ifdef UART_LINK_PARITY_EN
            PARITY:  txd_d = tx_par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            txd      <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh  <= tx_sh_d;
`ifdef UART_LINK_PARITY_EN
        tx_par <= tx_par_d;
`endif
    end

    assign tx_busy = (tx_state != IDLE) || (tx_fifo_count != '0);

    // RX: a start edge needs the line high first, so a held-low break cannot retrigger
    logic [1:0]           sync;
    logic                 rx_s, rx_prev, rx_mid;
    state_t               rx_state, rx_state_d;
    logic [OSW-1:0]       rx_cnt, rx_cnt_d;
    logic [BW-1:0]        rx_bit, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_d, rx_data_d;
    logic                 rx_valid_d, rx_ferr_d;
`ifdef UART_LINK_PARITY_EN
    logic                 rx_par, rx_par_d, rx_perr_d;
`endif

    assign rx_s = sync[1];

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_sh_d    = rx_sh;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        rx_ferr_d  = rx_frame_err;
`ifdef UART_LINK_PARITY_EN
        rx_par_d   = rx_par;
        rx_perr_d  = rx_parity_err;
`endif
        rx_mid = tick && (rx_cnt == ((rx_state == START) ? OS_MID : OS_LAST));
        if (rx_state != IDLE && tick) rx_cnt_d = rx_mid ? '0 : rx_cnt + 1'b1;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_d = START;
                    rx_cnt_d   = '0;
                end
            end
            START: begin
                if (rx_mid) begin
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_mid) begin
                    rx_sh_d  = {rx_s, rx_sh[DATA_BITS-1:1]};
                    rx_bit_d = rx_bit + 1'b1;
                    if (rx_bit == BIT_LAST) begin
`ifdef UART_LINK_PARITY_EN
                        rx_state_d = PARITY;
`else
                        rx_state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_LINK_PARITY_EN
            PARITY: begin
                if (rx_mid) begin
                    rx_par_d   = rx_s;
                    rx_state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_mid) begin
                    rx_state_d = IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh;
                    rx_ferr_d  = !rx_s;
`ifdef UART_LINK_PARITY_EN
                    rx_perr_d  = rx_par ^ (^rx_sh);
`endif
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync          <= 2'b11;
            rx_prev       <= 1'b1;
            rx_state      <= IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_frame_err  <= 1'b0;
`ifdef UART_LINK_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            sync          <= {sync[0], rxd};
            rx_prev       <= rx_s;
            rx_state      <= rx_state_d;
            rx_cnt        <= rx_cnt_d;
            rx_bit        <= rx_bit_d;
            rx_valid      <= rx_valid_d;
            rx_data       <= rx_data_d;
            rx_frame_err  <= rx_ferr_d;
`ifdef UART_LINK_PARITY_EN
            rx_parity_err <= rx_perr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        rx_sh  <= rx_sh_d;
`ifdef UART_LINK_PARITY_EN
        rx_par <= rx_par_d;
`endif
    end

`ifndef UART_LINK_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_link_core.md
UART_LINK_CORE -- requirements
Module: uart_link_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, RX/TX ticks per bit (even, >=8).
REQ-004 SHALL have parameter DATA_BITS, default 8, payload bits per frame (5..9).
REQ-005 SHALL have parameter TX_FIFO_DEPTH, default 4, TX buffer entries (power of 2, >=2).
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports tx_data (input, DATA_BITS, word to send), tx_valid (input, 1, push request) and tx_ready (output, 1, FIFO not full).
REQ-009 SHALL have ports tx_fifo_count (output, clog2(TX_FIFO_DEPTH)+1, buffered words), txd (output, 1, serial out) and tx_busy (output, 1, frame in progress or FIFO non-empty).
REQ-010 SHALL have ports rxd (input, 1, asynchronous serial in), rx_data (output, DATA_BITS, last word), rx_valid (output, 1, one-cycle strobe), rx_frame_err (output, 1) and rx_parity_err (output, 1).

Function
REQ-011 Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated; one-cycle tick every DIV clocks (default 27); counter free-runs, shared by TX and RX.
REQ-012 Frame: 1 start bit (0), DATA_BITS data LSB first, optional parity (REQ-029), 1 stop bit (1); each bit lasts OVERSAMPLE ticks.
REQ-013 Push: word written when tx_valid && tx_ready on a rising edge; tx_valid while tx_ready=0 is ignored, no error.
REQ-014 tx_ready = (tx_fifo_count < TX_FIFO_DEPTH), registered from count; no full-FIFO bypass for simultaneous push+pop.
REQ-015 Simultaneous push and pop in one cycle: count unchanged, both operations take effect; pointers wrap modulo TX_FIFO_DEPTH.
REQ-016 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on first tick with FIFO non-empty, pop on that transition, txd=0 from the following clock.
REQ-017 START->DATA->(PARITY)->STOP after OVERSAMPLE ticks per bit; STOP->IDLE after OVERSAMPLE ticks; back-to-back words have no idle gap beyond tick alignment.
REQ-018 txd registered; 1 in IDLE and STOP.
REQ-019 RX: rxd passes 2-flop synchroniser; RX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE->START on synchronised 1->0 edge; tick counter reset to 0 at edge.
REQ-021 START: sample at tick OVERSAMPLE/2-1; sample=1 -> IDLE (glitch rejected, no strobe); sample=0 -> DATA.
REQ-022 DATA/PARITY/STOP bits sampled once per bit at mid-bit (every OVERSAMPLE ticks after start mid-sample).
REQ-023 At STOP mid-sample: rx_data updated, rx_valid pulses exactly one clock, rx_frame_err = (stop sample==0), rx_parity_err per REQ-029; FSM -> IDLE same cycle, ready for next edge.
REQ-024 rx_data, rx_frame_err, rx_parity_err hold until next STOP sample; no receive backpressure, no overrun flag.
REQ-025 A framing-error frame still strobes rx_valid; if stop sampled 0, IDLE waits for rxd=1 before accepting a new edge (break condition).

Reset
REQ-026 rst asserted at any time, including mid-frame, SHALL immediately: txd=1, tx_busy=0, tx_ready=1, tx_fifo_count=0, FIFO emptied, both FSMs IDLE, tick counter 0, rx_valid=0, rx_data=0, both error flags 0, synchroniser flops=1.
REQ-027 After rst deasserts, the first frame SHALL begin no earlier than the first tick following a push.
REQ-028 A partial RX frame interrupted by reset SHALL NOT produce rx_valid.

Configuration
REQ-029 Macro UART_LINK_PARITY_EN defined: PARITY state active, TX sends even parity (XOR of data bits), RX sets rx_parity_err when received parity mismatches; frame = DATA_BITS+3 bits.
REQ-030 Macro UART_LINK_PARITY_EN undefined: PARITY state absent from both FSMs, frame = DATA_BITS+2 bits, rx_parity_err tied 0.

Verification
REQ-031 Defaults, push 8'hA5 -> txd 0,1,0,1,0,0,1,0,1,(parity 0 if enabled),1; each bit 432 clocks +/- 27.
REQ-032 Loop txd->rxd, push 8'h00, 8'hFF, 8'h3C back-to-back -> three rx_valid strobes, rx_data 00, FF, 3C, no errors, tx_busy low after last stop bit.
REQ-033 Push 6 words with TX_FIFO_DEPTH=4 while holding tx_valid -> tx_ready low at count 4, only accepted words transmitted, order preserved.
REQ-034 rxd low pulse of 100 clocks -> no rx_valid; valid frame 8'h5A with stop bit forced 0 -> rx_valid with rx_frame_err=1, rx_data 5A.
REQ-035 Parity enabled, frame 8'h01 with parity bit 0 -> rx_valid, rx_parity_err=1.
REQ-036 Assert rst mid-DATA of TX and RX -> txd=1 next cycle, count 0, no rx_valid; subsequent push 8'hC3 received correctly.
